// File: rtl/irq_pending_latch_if.sv
// Request/ack bundle between the interrupt source side and irq_pending_latch.
// The master drives requests, mask and acknowledges; the slave returns pending state.
interface irq_pending_latch_if #(
    parameter int N    = 8,
    parameter int IDXW = 3
);
    logic [N-1:0]    irq_in;
    logic [N-1:0]    mask;
    logic            ack;
    logic [IDXW-1:0] ack_idx;
    logic            clr_all;
    logic [N-1:0]    raw_pend;
    logic [N-1:0]    pend;
    logic            irq_valid;
    logic            ack_err;
    logic [N-1:0]    ovf;

    modport master (
        output irq_in, mask, ack, ack_idx, clr_all,
        input  raw_pend, pend, irq_valid, ack_err, ovf
    );

    modport slave (
        input  irq_in, mask, ack, ack_idx, clr_all,
        output raw_pend, pend, irq_valid, ack_err, ovf
    );
endinterface

// File: rtl/irq_pending_latch.sv
// Sticky rising-edge interrupt latch with per-line mask and indexed acknowledge.
// Optional sticky overflow flags are built only when IRQ_OVF_EN is defined.
module irq_pending_latch #(
    parameter int N    = 8,
    parameter int IDXW = 3
) (
    input logic                clk,
    input logic                rst_n,
    irq_pending_latch_if.slave bus
);

    logic [N-1:0] irq_d_p0;
    logic [N-1:0] raw_pend_p0;
    logic         ack_err_p0;
    logic [N-1:0] rise;
    logic [N-1:0] clr;
    logic [N-1:0] pend;
    logic         ack_hit;

    // Indices with no matching line (N not a power of 2) read as not pending.
    function automatic logic pending_at(input logic [N-1:0] vec, input logic [IDXW-1:0] idx);
        logic hit;
        hit = 1'b0;
        for (int b = 0; b < N; b++) begin
            if (idx == IDXW'(b)) hit = vec[b];
        end
        return hit;
    endfunction

    always_comb begin
        rise = bus.irq_in & ~irq_d_p0;
        clr  = {N{bus.clr_all}};
        if (bus.ack) begin
            for (int b = 0; b < N; b++) begin
                if (bus.ack_idx == IDXW'(b)) clr[b] = 1'b1;
            end
        end
        ack_hit = pending_at(raw_pend_p0, bus.ack_idx);
    end

    // Stage p0: edge-detect history, pending bits and ack error pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_d_p0    <= '0;
            raw_pend_p0 <= '0;
            ack_err_p0  <= 1'b0;
        end else begin
            irq_d_p0    <= bus.irq_in;
            raw_pend_p0 <= rise | (raw_pend_p0 & ~clr);
            ack_err_p0  <= bus.ack & ~bus.clr_all & ~ack_hit;
        end
    end

`ifdef IRQ_OVF_EN
    logic [N-1:0] ovf_p0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_p0 <= '0;
        end else if (bus.clr_all) begin
            ovf_p0 <= '0;
        end else begin
            ovf_p0 <= ovf_p0 | (rise & raw_pend_p0 & ~clr);
        end
    end

    assign bus.ovf = ovf_p0;
`else
    assign bus.ovf = '0;
`endif

    assign pend          = raw_pend_p0 & ~bus.mask;
    assign bus.raw_pend  = raw_pend_p0;
    assign bus.pend      = pend;
    assign bus.irq_valid = |pend;
    assign bus.ack_err   = ack_err_p0;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Bench for irq_pending_latch: directed vector table plus randomized run against
// a per-line event model. Build with IRQ_OVF_EN to exercise the overflow flags.
module tb_irq_pending_latch;

    localparam int N = 8;
    localparam int IDXW = 3;
`ifdef IRQ_OVF_EN
    localparam logic [7:0] OVF_HIT = 8'h20;
`else
    localparam logic [7:0] OVF_HIT = 8'h00;
`endif

    logic clk;
    logic rst_n;
    irq_pending_latch_if #(.N(N), .IDXW(IDXW)) bus ();

    irq_pending_latch #(.N(N), .IDXW(IDXW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [7:0] irq;
        logic [7:0] mask;
        logic       ack;
        logic [2:0] idx;
        logic       clr;
        logic [7:0] e_raw;
        logic [7:0] e_pend;
        logic       e_err;
        logic [7:0] e_ovf;
    } vec_t;

    vec_t tbl[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference model: one record per line, stepped once per clock edge.
    bit m_pend[N];
    bit m_prev[N];
    bit m_ovf[N];
    bit m_err;

    task automatic add(input logic r, input logic [7:0] irq, input logic [7:0] mask,
                       input logic ack, input logic [2:0] idx, input logic clr,
                       input logic [7:0] e_raw, input logic [7:0] e_pend,
                       input logic e_err, input logic [7:0] e_ovf);
        vec_t v;
        v.rst_n = r; v.irq = irq; v.mask = mask; v.ack = ack; v.idx = idx; v.clr = clr;
        v.e_raw = e_raw; v.e_pend = e_pend; v.e_err = e_err; v.e_ovf = e_ovf;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [7:0] irq, input logic ack,
                              input logic [2:0] idx, input logic clr);
        bit was_pending;
        if (!r) begin
            for (int b = 0; b < N; b++) begin
                m_pend[b] = 0; m_prev[b] = 0; m_ovf[b] = 0;
            end
            m_err = 0;
            return;
        end
        was_pending = (int'(idx) < N) ? m_pend[idx] : 1'b0;
        m_err = ack && !clr && !was_pending;
        for (int b = 0; b < N; b++) begin
            bit new_event, cleared;
            new_event = irq[b] && !m_prev[b];
            cleared   = clr || (ack && int'(idx) == b);
`ifdef IRQ_OVF_EN
            if (clr) m_ovf[b] = 0;
            else if (new_event && m_pend[b] && !cleared) m_ovf[b] = 1;
`endif
            if (new_event) m_pend[b] = 1;
            else if (cleared) m_pend[b] = 0;
            m_prev[b] = irq[b];
        end
    endtask

    task automatic model_check(input string tag, input logic [7:0] mask);
        logic [7:0] raw, ov;
        for (int b = 0; b < N; b++) begin
            raw[b] = m_pend[b];
            ov[b]  = m_ovf[b];
        end
        chk({tag, " raw_pend"}, bus.raw_pend, raw);
        chk({tag, " pend"}, bus.pend, raw & ~mask);
        chk({tag, " irq_valid"}, {7'd0, bus.irq_valid}, {7'd0, |(raw & ~mask)});
        chk({tag, " ack_err"}, {7'd0, bus.ack_err}, {7'd0, m_err});
        chk({tag, " ovf"}, bus.ovf, ov);
    endtask

    // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
    task automatic apply(input logic r, input logic [7:0] irq, input logic [7:0] mask,
                         input logic ack, input logic [2:0] idx, input logic clr);
        rst_n = r; bus.irq_in = irq; bus.mask = mask;
        bus.ack = ack; bus.ack_idx = idx; bus.clr_all = clr;
        @(posedge clk);
        model_edge(r, irq, ack, idx, clr);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; bus.irq_in = '0; bus.mask = '0;
        bus.ack = 1'b0; bus.ack_idx = '0; bus.clr_all = 1'b0;
        #1;

        // Reset with all lines high, then release
        add(0, 8'hFF, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        add(0, 8'hFF, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        add(1, 8'hFF, 8'h00, 0, 0, 0, 8'hFF, 8'hFF, 0, 8'h00);
        add(1, 8'h00, 8'h00, 0, 0, 0, 8'hFF, 8'hFF, 0, 8'h00);
        add(1, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0, 8'h00);
        // One-hot walk, then ack 7..0
        for (int k = 0; k < 8; k++)
            add(1, 8'(1 << k), 8'h00, 0, 0, 0, 8'((1 << (k + 1)) - 1), 8'((1 << (k + 1)) - 1), 0, 8'h00);
        for (int k = 7; k >= 0; k--)
            add(1, 8'h00, 8'h00, 1, 3'(k), 0, 8'((1 << k) - 1), 8'((1 << k) - 1), 0, 8'h00);
        // Mask hides but keeps pending
        add(1, 8'h11, 8'h0F, 0, 0, 0, 8'h11, 8'h10, 0, 8'h00);
        add(1, 8'h00, 8'h0F, 0, 0, 0, 8'h11, 8'h10, 0, 8'h00);
        add(1, 8'h00, 8'h00, 0, 0, 0, 8'h11, 8'h11, 0, 8'h00);
        add(1, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0, 8'h00);
        // Set beats ack on the same bit; re-edge on pending bit 5
        add(1, 8'h08, 8'h00, 0, 0, 0, 8'h08, 8'h08, 0, 8'h00);
        add(1, 8'h00, 8'h00, 0, 0, 0, 8'h08, 8'h08, 0, 8'h00);
        add(1, 8'h08, 8'h00, 1, 3, 0, 8'h08, 8'h08, 0, 8'h00);
        add(1, 8'h20, 8'h00, 0, 0, 0, 8'h28, 8'h28, 0, 8'h00);
        add(1, 8'h00, 8'h00, 0, 0, 0, 8'h28, 8'h28, 0, 8'h00);
        add(1, 8'h20, 8'h00, 0, 0, 0, 8'h28, 8'h28, 0, OVF_HIT);
        // Ack on a clear bit, then clr_all together with ack
        add(1, 8'h00, 8'h00, 1, 2, 0, 8'h28, 8'h28, 1, OVF_HIT);
        add(1, 8'h00, 8'h00, 0, 0, 0, 8'h28, 8'h28, 0, OVF_HIT);
        add(1, 8'h00, 8'h00, 1, 3, 1, 8'h00, 8'h00, 0, 8'h00);
        // Level held on line 0, acked once, re-armed only by low->high
        add(1, 8'h01, 8'h00, 0, 0, 0, 8'h01, 8'h01, 0, 8'h00);
        add(1, 8'h01, 8'h00, 0, 0, 0, 8'h01, 8'h01, 0, 8'h00);
        add(1, 8'h01, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        for (int k = 0; k < 7; k++)
            add(1, 8'h01, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        add(1, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        add(1, 8'h01, 8'h00, 0, 0, 0, 8'h01, 8'h01, 0, 8'h00);

        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("row%0d", i);
            apply(tbl[i].rst_n, tbl[i].irq, tbl[i].mask, tbl[i].ack, tbl[i].idx, tbl[i].clr);
            chk({tag, " raw_pend"}, bus.raw_pend, tbl[i].e_raw);
            chk({tag, " pend"}, bus.pend, tbl[i].e_pend);
            chk({tag, " irq_valid"}, {7'd0, bus.irq_valid}, {7'd0, |tbl[i].e_pend});
            chk({tag, " ack_err"}, {7'd0, bus.ack_err}, {7'd0, tbl[i].e_err});
            chk({tag, " ovf"}, bus.ovf, tbl[i].e_ovf);
        end

        for (int i = 0; i < 400; i++) begin
            logic       r, ack, clr;
            logic [7:0] irq, mask;
            logic [2:0] idx;
            r    = ($urandom_range(63) != 0);
            irq  = 8'($urandom) & 8'($urandom);
            mask = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
            ack  = ($urandom_range(2) == 0);
            idx  = 3'($urandom);
            clr  = ($urandom_range(31) == 0);
            apply(r, irq, mask, ack, idx, clr);
            model_check($sformatf("rnd%0d", i), mask);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
